// File: rtl/clk_div_pkg.sv
// Shared helpers for the stopwatch clock divider: half-period and counter-width arithmetic.
package clk_div_pkg;

  function automatic int unsigned half_period(input int unsigned clk_hz,
                                              input int unsigned out_hz);
    return clk_hz / (2 * out_hz);
  endfunction

  // A counter that only ever holds 0 still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned half);
    return (half <= 2) ? 1 : $clog2(half);
  endfunction

endpackage

// File: rtl/div_toggle.sv
// One divider stage: counts HALF clk edges, then toggles q, giving a 2*HALF-cycle square wave.
module div_toggle
  import clk_div_pkg::*;
#(
  parameter int unsigned HALF = 1
) (
  input  logic clk,
  input  logic rst,
  output logic q
);

  localparam int unsigned W = cnt_width(HALF);
  localparam logic [W-1:0] LAST = W'(HALF - 1);

  if (HALF < 1) begin : g_bad_half
    $error("div_toggle: HALF must be at least 1 (got %0d)", HALF);
  end

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (cnt == LAST) begin
      cnt <= '0;
      q   <= ~q;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/clk_div.sv
// Stopwatch clock divider: four free-running, phase-aligned square waves derived from clk.
module clk_div
  import clk_div_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned ONE_HZ   = 1,
  parameter int unsigned TWO_HZ   = 2,
  parameter int unsigned BLINK_HZ = 4,
  parameter int unsigned FAST_HZ  = 500
) (
  input  logic clk,
  input  logic rst,
  output logic One_Hz,
  output logic Two_Hz,
  output logic Blink,
  output logic Fast
);

  localparam int unsigned H_ONE   = half_period(CLK_HZ, ONE_HZ);
  localparam int unsigned H_TWO   = half_period(CLK_HZ, TWO_HZ);
  localparam int unsigned H_BLINK = half_period(CLK_HZ, BLINK_HZ);
  localparam int unsigned H_FAST  = half_period(CLK_HZ, FAST_HZ);

  div_toggle #(.HALF(H_ONE)) u_one (
    .clk (clk),
    .rst (rst),
    .q   (One_Hz)
  );

  div_toggle #(.HALF(H_TWO)) u_two (
    .clk (clk),
    .rst (rst),
    .q   (Two_Hz)
  );

  div_toggle #(.HALF(H_BLINK)) u_blink (
    .clk (clk),
    .rst (rst),
    .q   (Blink)
  );

  div_toggle #(.HALF(H_FAST)) u_fast (
    .clk (clk),
    .rst (rst),
    .q   (Fast)
  );

endmodule

// File: tb/tb_clk_div.sv
// Bench for clk_div: randomized run lengths and async resets against an edge-count model.
module tb_clk_div;

  localparam int unsigned HV  [4] = '{500, 250, 125, 5};
  localparam int unsigned HV2 [4] = '{500, 250, 125, 1};

  logic       clk;
  logic       rst;
  logic [3:0] q;
  logic [3:0] q2;

  clk_div #(
    .CLK_HZ(1000), .ONE_HZ(1), .TWO_HZ(2), .BLINK_HZ(4), .FAST_HZ(100)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .One_Hz (q[0]),
    .Two_Hz (q[1]),
    .Blink  (q[2]),
    .Fast   (q[3])
  );

  clk_div #(
    .CLK_HZ(1000), .ONE_HZ(1), .TWO_HZ(2), .BLINK_HZ(4), .FAST_HZ(500)
  ) dut_h1 (
    .clk    (clk),
    .rst    (rst),
    .One_Hz (q2[0]),
    .Two_Hz (q2[1]),
    .Blink  (q2[2]),
    .Fast   (q2[3])
  );

  int checks;
  int failures;

  // Clock edges seen since the last reset release.
  int n;

  logic [3:0] prev;
  int         last_rise [4];
  int         last_fall [4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) n <= 0;
    else      n <= n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t n=%0d)", tag, got, exp, $time, n);
    end
  endtask

  // After e edges an output with half-period h has toggled floor(e/h) times.
  function automatic logic model(input int e, input int unsigned h);
    return ((e / int'(h)) % 2) == 1;
  endfunction

  task automatic clear_tracking();
    prev = 4'b0;
    for (int k = 0; k < 4; k++) begin
      last_rise[k] = -1;
      last_fall[k] = -1;
    end
  endtask

  task automatic sample_cycle();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("level_%0d", k), 32'(q[k]),
            rst ? 32'(model(n, HV[k])) : 32'd0);
      check($sformatf("level_h1_%0d", k), 32'(q2[k]),
            rst ? 32'(model(n, HV2[k])) : 32'd0);
      if (q[k] && !prev[k]) begin
        if (last_rise[k] < 0) check($sformatf("first_rise_%0d", k), 32'(n), 32'(HV[k]));
        else check($sformatf("period_%0d", k), 32'(n - last_rise[k]), 32'(2 * HV[k]));
        if (last_fall[k] >= 0)
          check($sformatf("low_time_%0d", k), 32'(n - last_fall[k]), 32'(HV[k]));
        last_rise[k] = n;
      end else if (!q[k] && prev[k]) begin
        check($sformatf("high_time_%0d", k), 32'(n - last_rise[k]), 32'(HV[k]));
        last_fall[k] = n;
      end
    end
    if (q[0] != prev[0]) begin
      check("align_two", 32'(q[1] != prev[1]), 32'd1);
      check("align_blink", 32'(q[2] != prev[2]), 32'd1);
    end
    prev = q;
  endtask

  // Counts posedges from a between-edges release until Fast first goes high.
  task automatic fast_first_rise();
    int cnt;
    cnt = 0;
    while (cnt < 20) begin
      @(posedge clk);
      cnt++;
      #1;
      if (q[3]) break;
    end
    check("fast_first_rise_edges", 32'(cnt), 32'd5);
  endtask

  initial begin
    int waited;
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    clear_tracking();

    repeat (5) sample_cycle();
    check("reset_outputs", 32'(q), 32'd0);

    #2 rst = 1'b1;
    fast_first_rise();
    repeat (2000) sample_cycle();

    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 400)) sample_cycle();
      waited = 0;
      while (!q[3] && waited < 20) begin
        sample_cycle();
        waited++;
      end
      check("fast_high_before_reset", 32'(q[3]), 32'd1);

      #($urandom_range(1, 3)) rst = 1'b0;
      #1;
      check("async_reset_outputs", 32'(q), 32'd0);
      check("async_reset_outputs_h1", 32'(q2), 32'd0);
      clear_tracking();

      repeat ($urandom_range(1, 5)) sample_cycle();
      #($urandom_range(1, 3)) rst = 1'b1;
      fast_first_rise();
      repeat ($urandom_range(150, 700)) sample_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
